// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin operand-path arbiter: sizes, FSM
// encoding and the rotate-priority pick function.
package mux_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  // The result is only meaningful when req is non-zero.
  function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] req,
                                            input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    pick = ptr;
    // Scan from the farthest offset down so the nearest one wins.
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake/data bundle between the requesters and the arbiter.
interface mux_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  import mux_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [SEL_W-1:0]         select;
  logic                     busy;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;

  modport master (
    output req, data_in,
    input  gnt, select, busy, out_valid, out_data
  );

  modport slave (
    input  req, data_in,
    output gnt, select, busy, out_valid, out_data
  );

endinterface

// File: rtl/mux_rr_arbiter_mux4.sv
// One bit slice of the shared 4:1 operand multiplexer.
module mux_rr_arbiter_mux4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] d_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic               y_o
);

  always_comb begin
    y_o = 1'b0;
    unique case (sel_i)
      2'd0: y_o = d_i[0];
      2'd1: y_o = d_i[1];
      2'd2: y_o = d_i[2];
      2'd3: y_o = d_i[3];
      default: y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded burst hold, driving a bit-sliced 4:1 mux
// tree and registering the selected word.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus_io
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  state_e             state_q;
  logic [SEL_W-1:0]   owner_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [HoldW-1:0]   hold_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;

  logic [WIDTH-1:0]   mux_word;
  logic               owner_req;
  logic               release_now;
  logic [SEL_W-1:0]   idle_pick;
  logic [SEL_W-1:0]   next_pick;

  // Mux tree: one 4:1 slice per data bit, steered by the registered owner.
  for (genvar b = 0; b < int'(WIDTH); b++) begin : g_slice
    mux_rr_arbiter_mux4 u_mux4 (
      .d_i   ({bus_io.data_in[3*WIDTH+b], bus_io.data_in[2*WIDTH+b],
               bus_io.data_in[WIDTH+b],   bus_io.data_in[b]}),
      .sel_i (owner_q),
      .y_o   (mux_word[b])
    );
  end

  always_comb begin
    owner_req   = bus_io.req[owner_q];
    release_now = !owner_req || (hold_q == HoldLast);
    idle_pick   = pick(bus_io.req, ptr_q);
    next_pick   = pick(bus_io.req, owner_q + SEL_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|bus_io.req) begin
            owner_q <= idle_pick;
            gnt_q   <= NUM_REQ'(1) << idle_pick;
            hold_q  <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (owner_req) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_word;
          end
          if (release_now) begin
            ptr_q <= owner_q + SEL_W'(1);
            if (|bus_io.req) begin
              // Hand over without a bubble; may re-grant the same owner.
              owner_q <= next_pick;
              gnt_q   <= NUM_REQ'(1) << next_pick;
              hold_q  <= '0;
            end else begin
              gnt_q   <= '0;
              state_q <= StIdle;
            end
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.gnt       = gnt_q;
  assign bus_io.select    = owner_q;
  assign bus_io.busy      = (state_q == StGrant);
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: a MAX_HOLD=4 arbiter and a MAX_HOLD=1 arbiter on one clock.
module tb_mux_rr_arbiter;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mux_rr_arbiter_if #(.WIDTH(W)) bus4 ();
  mux_rr_arbiter_if #(.WIDTH(W)) bus1 ();

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus4.slave)
  );

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " gnt4"},  bus4.gnt,       0);
    check_eq({tag, " sel4"},  bus4.select,    0);
    check_eq({tag, " busy4"}, bus4.busy,      0);
    check_eq({tag, " ov4"},   bus4.out_valid, 0);
    check_eq({tag, " od4"},   bus4.out_data,  0);
    check_eq({tag, " gnt1"},  bus1.gnt,       0);
    check_eq({tag, " ov1"},   bus1.out_valid, 0);
  endtask

  logic [7:0] w4 [4];
  logic [7:0] w1 [4];
  int         own;
  int         prev_own;

  initial begin
    n_cmp = 0;
    n_err = 0;
    w4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    w1 = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};

    // Reset held with random inputs.
    rst_n        = 1'b0;
    bus4.req     = 4'($urandom);
    bus4.data_in = $urandom;
    bus1.req     = 4'($urandom);
    bus1.data_in = $urandom;
    tick();
    tick();
    check_reset_outputs("reset");
    bus4.req = '0;
    bus1.req = '0;
    tick();
    rst_n = 1'b1;

    // Single requester 2, bursts re-granted without a gap.
    bus4.data_in = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
    bus4.req     = 4'b0100;
    tick();
    check_eq("single first gnt", bus4.gnt, 4'b0100);
    check_eq("single first ov", bus4.out_valid, 0);
    check_eq("single busy", bus4.busy, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("single gnt %0d", i), bus4.gnt, 4'b0100);
      check_eq($sformatf("single ov %0d", i), bus4.out_valid, 1);
      check_eq($sformatf("single od %0d", i), bus4.out_data, 8'hA5);
    end
    bus4.req = '0;
    tick();
    check_eq("single idle gnt", bus4.gnt, 0);
    check_eq("single idle ov", bus4.out_valid, 0);
    check_eq("single idle busy", bus4.busy, 0);
    check_eq("single idle sel", bus4.select, 2);
    check_eq("single idle od hold", bus4.out_data, 8'hA5);

    // Reset again so the rotation starts at ptr=0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // All requesting: 4 cycles per owner, order 0,1,2,3,0, no idle slots.
    bus4.data_in = {w4[3], w4[2], w4[1], w4[0]};
    bus4.req     = 4'b1111;
    prev_own     = 0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      own = ((n - 1) / 4) % 4;
      check_eq($sformatf("all gnt %0d", n), bus4.gnt, 4'b0001 << own);
      check_eq($sformatf("all sel %0d", n), bus4.select, own);
      if (n >= 2) begin
        check_eq($sformatf("all ov %0d", n), bus4.out_valid, 1);
        check_eq($sformatf("all od %0d", n), bus4.out_data, w4[prev_own]);
      end
      prev_own = own;
    end

    // Asynchronous reset mid-burst clears outputs before any clock edge.
    rst_n = 1'b0;
    #1;
    check_eq("async gnt", bus4.gnt, 0);
    check_eq("async ov", bus4.out_valid, 0);
    check_eq("async busy", bus4.busy, 0);
    check_eq("async sel", bus4.select, 0);
    check_eq("async od", bus4.out_data, 0);
    bus4.req = '0;
    #3;
    rst_n = 1'b1;
    tick();

    // Early drop: owner 0 leaves after two transfers, grant moves to 1.
    bus4.req = 4'b0011;
    tick();
    check_eq("drop gnt0", bus4.gnt, 4'b0001);
    tick();
    tick();
    check_eq("drop two xfers ov", bus4.out_valid, 1);
    check_eq("drop two xfers od", bus4.out_data, w4[0]);
    bus4.req = 4'b0010;
    tick();
    check_eq("drop handoff gnt", bus4.gnt, 4'b0010);
    check_eq("drop bubble ov", bus4.out_valid, 0);
    // ptr is now 1, so the owner-1 word follows.
    bus4.req = 4'b1011;
    tick();
    check_eq("drop resume ov", bus4.out_valid, 1);
    check_eq("drop resume od", bus4.out_data, w4[1]);

    // Fairness: owner 1 expires with 0,1,3 requesting -> 3 wins, not 1.
    tick();
    tick();
    check_eq("fair hold gnt", bus4.gnt, 4'b0010);
    tick();
    check_eq("fair expire gnt", bus4.gnt, 4'b1000);
    check_eq("fair expire od", bus4.out_data, w4[1]);
    bus4.req = 4'b0011;
    tick();
    check_eq("fair wrap gnt", bus4.gnt, 4'b0001);
    check_eq("fair wrap ov", bus4.out_valid, 0);
    bus4.req = '0;
    tick();

    // MAX_HOLD=1: grant rotates every cycle.
    bus1.data_in = {w1[3], w1[2], w1[1], w1[0]};
    bus1.req     = 4'b1111;
    tick();
    check_eq("mh1 gnt first", bus1.gnt, 4'b0001);
    for (int n = 1; n <= 5; n++) begin
      tick();
      check_eq($sformatf("mh1 gnt %0d", n), bus1.gnt, 4'b0001 << (n % 4));
      check_eq($sformatf("mh1 ov %0d", n), bus1.out_valid, 1);
      check_eq($sformatf("mh1 od %0d", n), bus1.out_data, w1[(n - 1) % 4]);
    end
    bus1.req = '0;
    tick();
    tick();
    check_eq("mh1 idle gnt", bus1.gnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
